// File: rtl/multichannel_serializer.sv
// Multi-channel parallel-to-serial converter for the DAC output path.
// Each frame carries one WIDTH-bit word per channel. Frames arrive over a
// valid/ready handshake into a holding register, so the next frame can wait
// there while the current one is shifted out. Every channel has its own
// serial line. The bit clock (sclk) and the frame sync (fsync) are divided
// down from clk. If no frame is waiting at a word boundary, the block sends
// zeros, raises an underrun pulse and bumps a saturating counter.
module multichannel_serializer #(
    parameter int WIDTH     = 8,
    parameter int N_CH      = 2,
    parameter int CLK_HALF  = 2,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    sclk,
    output logic                    fsync,
    output logic [N_CH-1:0]         sdata,
    output logic                    underrun,
    output logic [CNT_W-1:0]        underrun_count,
    output logic                    busy
);

    localparam int FW    = N_CH * WIDTH;
    localparam int DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [FW-1:0]      shift_q, shift_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic               fsync_q, fsync_d;
    logic [N_CH-1:0]    sdata_q;
    logic               underrun_q, underrun_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q;
    logic               accept_s;

    // Move every channel word by one bit. The bit that leaves sits at the
    // output end of the word; a zero enters at the other end.
    function automatic logic [FW-1:0] advance_word(input logic [FW-1:0] w);
        logic [FW-1:0] r;
        r = {FW{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            if (MSB_FIRST != 0) begin
                r[c*WIDTH +: WIDTH] = {w[c*WIDTH +: WIDTH-1], 1'b0};
            end else begin
                r[c*WIDTH +: WIDTH] = {1'b0, w[c*WIDTH+1 +: WIDTH-1]};
            end
        end
        return r;
    endfunction

    // Pick the current output bit of each channel word.
    function automatic logic [N_CH-1:0] out_bits(input logic [FW-1:0] w);
        logic [N_CH-1:0] r;
        r = {N_CH{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            if (MSB_FIRST != 0) begin
                r[c] = w[c*WIDTH + WIDTH - 1];
            end else begin
                r[c] = w[c*WIDTH];
            end
        end
        return r;
    endfunction

    assign accept_s = in_valid && !hold_full_q;

    // Next-state logic: handshake, bit-clock divider, shift and word boundary.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        fsync_d     = fsync_q;
        underrun_d  = 1'b0;
        cnt_d       = cnt_q;

        // Accepting and loading never happen on the same edge. Accepting
        // needs an empty holding register; loading needs a full one.
        if (accept_s) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && hold_full_q) begin
                    state_d     = ST_RUN;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_d       = {BIT_W{1'b0}};
                    div_d       = {DIV_W{1'b0}};
                    sclk_d      = 1'b0;
                    fsync_d     = 1'b1;
                end else begin
                    shift_d     = {FW{1'b0}};
                    bit_d       = {BIT_W{1'b0}};
                    div_d       = {DIV_W{1'b0}};
                    sclk_d      = 1'b0;
                    fsync_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Stop at once. The current word is discarded, but a
                    // frame already in the holding register is kept.
                    state_d = ST_IDLE;
                    shift_d = {FW{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    div_d   = {DIV_W{1'b0}};
                    sclk_d  = 1'b0;
                    fsync_d = 1'b0;
                end else if (div_q == DIV_LAST) begin
                    div_d  = {DIV_W{1'b0}};
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        // sclk is falling, so data and fsync change here and
                        // are stable at the next rising edge, when the DAC
                        // samples.
                        if (bit_q == BIT_LAST) begin
                            bit_d   = {BIT_W{1'b0}};
                            fsync_d = 1'b1;
                            if (hold_full_q) begin
                                shift_d     = hold_q;
                                hold_full_d = 1'b0;
                            end else begin
                                shift_d    = {FW{1'b0}};
                                underrun_d = 1'b1;
                                cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                            end
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            fsync_d = 1'b0;
                            shift_d = advance_word(shift_q);
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = {FW{1'b0}};
                bit_d   = {BIT_W{1'b0}};
                div_d   = {DIV_W{1'b0}};
                sclk_d  = 1'b0;
                fsync_d = 1'b0;
            end
        endcase
    end

    // State and output registers. sdata and busy are computed from the next
    // state, so they change on the same edge as the shift register and the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= {FW{1'b0}};
            hold_full_q <= 1'b0;
            shift_q     <= {FW{1'b0}};
            div_q       <= {DIV_W{1'b0}};
            bit_q       <= {BIT_W{1'b0}};
            sclk_q      <= 1'b0;
            fsync_q     <= 1'b0;
            sdata_q     <= {N_CH{1'b0}};
            underrun_q  <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            fsync_q     <= fsync_d;
            sdata_q     <= out_bits(shift_d);
            underrun_q  <= underrun_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign in_ready       = !hold_full_q;
    assign sclk           = sclk_q;
    assign fsync          = fsync_q;
    assign sdata          = sdata_q;
    assign underrun       = underrun_q;
    assign underrun_count = cnt_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multichannel_serializer.sv
// Bench for multichannel_serializer. Two instances share the same inputs:
// one shifts MSB first with a 2-bit underrun counter, the other shifts LSB
// first with an 8-bit counter. Both use WIDTH=4, N_CH=2 and CLK_HALF=1.
module tb_multichannel_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] in_data;
    logic       in_valid;

    logic       ready_m, sclk_m, fsync_m, underrun_m, busy_m;
    logic [1:0] sdata_m;
    logic [1:0] ucnt_m;
    logic       ready_l, sclk_l, fsync_l, underrun_l, busy_l;
    logic [1:0] sdata_l;
    logic [7:0] ucnt_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multichannel_serializer #(
        .WIDTH(4), .N_CH(2), .CLK_HALF(1), .MSB_FIRST(1), .CNT_W(2)
    ) dut_m (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ready_m), .sclk(sclk_m), .fsync(fsync_m),
        .sdata(sdata_m), .underrun(underrun_m), .underrun_count(ucnt_m), .busy(busy_m)
    );

    multichannel_serializer #(
        .WIDTH(4), .N_CH(2), .CLK_HALF(1), .MSB_FIRST(0), .CNT_W(8)
    ) dut_l (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ready_l), .sclk(sclk_l), .fsync(fsync_l),
        .sdata(sdata_l), .underrun(underrun_l), .underrun_count(ucnt_l), .busy(busy_l)
    );

    // One record per frame. Each sequence lists the bits in the order they
    // appear on the line; bit [3] comes out first.
    typedef struct {
        logic [7:0] data;
        logic [3:0] m0;   // MSB-first, channel 0
        logic [3:0] m1;   // MSB-first, channel 1
        logic [3:0] l0;   // LSB-first, channel 0
        logic [3:0] l1;   // LSB-first, channel 1
    } vec_t;

    vec_t vecs [4];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        enable   = 1'b1;
        in_data  = 8'h00;
        tick(2);
        reset    = 1'b0;
    endtask

    initial begin
        int ur_seen;
        int k;

        vecs[0] = '{data: 8'h5A, m0: 4'b1010, m1: 4'b0101, l0: 4'b0101, l1: 4'b1010};
        vecs[1] = '{data: 8'hC3, m0: 4'b0011, m1: 4'b1100, l0: 4'b1100, l1: 4'b0011};
        vecs[2] = '{data: 8'h81, m0: 4'b0001, m1: 4'b1000, l0: 4'b1000, l1: 4'b0001};
        vecs[3] = '{data: 8'h6E, m0: 4'b1110, m1: 4'b0110, l0: 4'b0111, l1: 4'b0110};

        // Reset state.
        do_reset();
        chk("rst sclk",   {31'd0, sclk_m},     32'd0);
        chk("rst fsync",  {31'd0, fsync_m},    32'd0);
        chk("rst sdata",  {28'd0, sdata_m, sdata_l}, 32'd0);
        chk("rst under",  {31'd0, underrun_m}, 32'd0);
        chk("rst busy",   {30'd0, busy_m, busy_l}, 32'd0);
        chk("rst ucnt",   {22'd0, ucnt_m, ucnt_l}, 32'd0);
        chk("rst ready",  {30'd0, ready_m, ready_l}, 32'd3);

        // Table-driven single frames. Accept at E1, load at E2, then 8 cycles
        // of output, 2 cycles per bit.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            in_data  = vecs[v].data;
            in_valid = 1'b1;
            tick(1);
            chk($sformatf("v%0d ready after accept", v), {31'd0, ready_m}, 32'd0);
            in_valid = 1'b0;
            tick(1);
            chk($sformatf("v%0d busy", v), {30'd0, busy_m, busy_l}, 32'd3);
            chk($sformatf("v%0d ready after load", v), {31'd0, ready_m}, 32'd1);
            for (int cyc = 0; cyc < 8; cyc++) begin
                k = 3 - cyc / 2;
                chk($sformatf("v%0d c%0d sdata msb", v, cyc), {30'd0, sdata_m},
                    {30'd0, vecs[v].m1[k], vecs[v].m0[k]});
                chk($sformatf("v%0d c%0d sdata lsb", v, cyc), {30'd0, sdata_l},
                    {30'd0, vecs[v].l1[k], vecs[v].l0[k]});
                chk($sformatf("v%0d c%0d fsync", v, cyc), {31'd0, fsync_m}, (cyc < 2) ? 32'd1 : 32'd0);
                chk($sformatf("v%0d c%0d sclk", v, cyc), {31'd0, sclk_m}, 32'(cyc % 2));
                tick(1);
            end
        end

        // Back-to-back frames 0x5A then 0xC3, then starvation.
        do_reset();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        tick(1);                                   // E1: accept 0x5A
        chk("b2b ready drop 1", {31'd0, ready_m}, 32'd0);
        in_data  = 8'hC3;                          // ignored at E2
        tick(1);                                   // E2: load 0x5A
        chk("b2b ready rise 1", {31'd0, ready_m}, 32'd1);
        tick(1);                                   // E3: accept 0xC3
        chk("b2b ready drop 2", {31'd0, ready_m}, 32'd0);
        in_valid = 1'b0;
        ur_seen = 0;
        for (int i = 0; i < 7; i++) begin          // E4..E10
            tick(1);
            ur_seen += int'(underrun_m) + int'(underrun_l);
            if (i == 5) begin                      // E9: last bit of 0x5A
                chk("b2b E9 fsync", {31'd0, fsync_m}, 32'd0);
                chk("b2b E9 sdata msb", {30'd0, sdata_m}, 32'd2);
            end
        end
        chk("b2b no underrun", 32'(ur_seen), 32'd0);
        chk("b2b 2nd fsync", {31'd0, fsync_m}, 32'd1);
        chk("b2b 2nd sdata msb", {30'd0, sdata_m}, 32'd2);
        chk("b2b 2nd sdata lsb", {30'd0, sdata_l}, 32'd1);
        chk("b2b ready rise 2", {31'd0, ready_m}, 32'd1);

        ur_seen = 0;
        for (int i = 0; i < 7; i++) begin          // E11..E17
            tick(1);
            ur_seen += int'(underrun_m);
        end
        chk("ur early", 32'(ur_seen), 32'd0);
        tick(1);                                   // E18: boundary, hold empty
        chk("ur pulse m", {31'd0, underrun_m}, 32'd1);
        chk("ur pulse l", {31'd0, underrun_l}, 32'd1);
        chk("ur count m", {30'd0, ucnt_m}, 32'd1);
        chk("ur count l", {24'd0, ucnt_l}, 32'd1);
        chk("ur sdata", {28'd0, sdata_m, sdata_l}, 32'd0);
        chk("ur fsync", {31'd0, fsync_m}, 32'd1);
        chk("ur busy", {31'd0, busy_m}, 32'd1);
        tick(1);                                   // E19
        chk("ur one cycle", {31'd0, underrun_m}, 32'd0);
        tick(31);                                  // E50: 5th underrun
        chk("ur 5th pulse", {31'd0, underrun_m}, 32'd1);
        chk("ur sat cnt2", {30'd0, ucnt_m}, 32'd3);
        chk("ur cnt8", {24'd0, ucnt_l}, 32'd5);

        // Accept on the same edge as an underrun boundary.
        tick(7);                                   // E57
        in_data  = 8'h81;
        in_valid = 1'b1;
        tick(1);                                   // E58
        in_valid = 1'b0;
        chk("sim underrun", {31'd0, underrun_l}, 32'd1);
        chk("sim ready", {31'd0, ready_l}, 32'd0);
        chk("sim cnt8", {24'd0, ucnt_l}, 32'd6);
        chk("sim cnt2", {30'd0, ucnt_m}, 32'd3);
        chk("sim sdata", {30'd0, sdata_l}, 32'd0);
        tick(8);                                   // E66: 0x81 loaded
        chk("sim load fsync", {31'd0, fsync_m}, 32'd1);
        chk("sim load sdata msb", {30'd0, sdata_m}, 32'd2);
        chk("sim load sdata lsb", {30'd0, sdata_l}, 32'd1);
        chk("sim load no ur", {31'd0, underrun_m}, 32'd0);
        chk("sim load ready", {31'd0, ready_m}, 32'd1);

        // Reset mid-word with a frame pending in the holding register.
        in_data  = 8'h6E;
        in_valid = 1'b1;
        tick(1);                                   // E67: accept
        in_valid = 1'b0;
        chk("rm hold full", {31'd0, ready_m}, 32'd0);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("rm outs", {26'd0, sclk_m, fsync_m, sdata_m, underrun_m, busy_m}, 32'd0);
        chk("rm ready", {31'd0, ready_m}, 32'd1);
        chk("rm ucnt", {22'd0, ucnt_m, ucnt_l}, 32'd0);
        reset = 1'b0;
        tick(2);
        chk("rm hold dropped", {30'd0, busy_m, busy_l}, 32'd0);

        // enable low mid-word, then resume from the held frame.
        do_reset();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        tick(1);                                   // E1 accept 0x5A
        in_data  = 8'hC3;
        tick(1);                                   // E2 load
        tick(1);                                   // E3 accept 0xC3
        in_valid = 1'b0;
        tick(2);                                   // E5: mid bit 1
        chk("en pre sdata", {30'd0, sdata_m}, 32'd2);
        enable = 1'b0;
        tick(1);                                   // E6
        chk("en off sclk", {31'd0, sclk_m}, 32'd0);
        chk("en off sdata", {28'd0, sdata_m, sdata_l}, 32'd0);
        chk("en off busy", {30'd0, busy_m, busy_l}, 32'd0);
        chk("en off fsync", {31'd0, fsync_m}, 32'd0);
        chk("en off hold kept", {31'd0, ready_m}, 32'd0);
        tick(1);                                   // E7 still idle
        chk("en idle busy", {31'd0, busy_m}, 32'd0);
        enable = 1'b1;
        tick(1);                                   // E8 restart with 0xC3
        chk("en on busy", {31'd0, busy_m}, 32'd1);
        chk("en on fsync", {31'd0, fsync_m}, 32'd1);
        chk("en on sclk", {31'd0, sclk_m}, 32'd0);
        chk("en on sdata msb", {30'd0, sdata_m}, 32'd2);
        chk("en on sdata lsb", {30'd0, sdata_l}, 32'd1);
        chk("en on ready", {31'd0, ready_m}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
